// File: rtl/wb_arbiter.sv
// wb_arbiter: writeback arbiter that buffers one EXU and one LSU result and
// serialises them onto the single register-file write port with commit/instret.
`default_nettype none

module wb_arbiter #(
  parameter int XLEN       = 32,
  parameter int WIDTH      = 5,
  parameter int STARVE_MAX = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             exu_valid,
  output logic             exu_ready,
  input  logic [WIDTH-1:0] exu_rd,
  input  logic [XLEN-1:0]  exu_wdata,
  input  logic             exu_wen,
  input  logic [XLEN-1:0]  exu_pc,
  input  logic             lsu_valid,
  output logic             lsu_ready,
  input  logic [WIDTH-1:0] lsu_rd,
  input  logic [XLEN-1:0]  lsu_wdata,
  input  logic             lsu_wen,
  input  logic [XLEN-1:0]  lsu_pc,
  output logic [WIDTH-1:0] rf_waddr,
  output logic [XLEN-1:0]  rf_wdata,
  output logic             rf_wen,
  output logic             commit_valid,
  output logic [XLEN-1:0]  commit_pc,
  output logic [63:0]      instret
);

  localparam int SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  typedef struct packed {
    logic [WIDTH-1:0] rd;
    logic [XLEN-1:0]  wdata;
    logic             wen;
    logic [XLEN-1:0]  pc;
  } res_t;

  logic             exu_v_q, exu_v_d;
  logic             lsu_v_q, lsu_v_d;
  res_t             exu_buf_q, exu_buf_d;
  res_t             lsu_buf_q, lsu_buf_d;
  logic [SW-1:0]    starve_q, starve_d;
  logic [WIDTH-1:0] rf_waddr_q, rf_waddr_d;
  logic [XLEN-1:0]  rf_wdata_q, rf_wdata_d;
  logic             rf_wen_q, rf_wen_d;
  logic             commit_valid_q, commit_valid_d;
  logic [XLEN-1:0]  commit_pc_q, commit_pc_d;
  logic [63:0]      instret_q, instret_d;

  logic sel_exu, sel_lsu, any_sel;
  logic exu_acc, lsu_acc;
  res_t sel_res;

  always_comb begin
    // LSU has priority on conflict unless the EXU has already lost STARVE_MAX times.
    sel_exu = exu_v_q && (!lsu_v_q || (starve_q == STARVE_LIM));
    sel_lsu = lsu_v_q && !sel_exu;
    any_sel = sel_exu || sel_lsu;
    sel_res = sel_exu ? exu_buf_q : lsu_buf_q;

    exu_ready = !exu_v_q || sel_exu;
    lsu_ready = !lsu_v_q || sel_lsu;
    exu_acc   = exu_valid && exu_ready;
    lsu_acc   = lsu_valid && lsu_ready;

    exu_v_d   = exu_acc ? 1'b1 : (sel_exu ? 1'b0 : exu_v_q);
    lsu_v_d   = lsu_acc ? 1'b1 : (sel_lsu ? 1'b0 : lsu_v_q);
    exu_buf_d = exu_acc ? res_t'{rd: exu_rd, wdata: exu_wdata, wen: exu_wen, pc: exu_pc} : exu_buf_q;
    lsu_buf_d = lsu_acc ? res_t'{rd: lsu_rd, wdata: lsu_wdata, wen: lsu_wen, pc: lsu_pc} : lsu_buf_q;

    if (exu_v_q && lsu_v_q && sel_lsu) begin
      starve_d = starve_q + SW'(1);
    end else if (sel_exu || !exu_v_q) begin
      starve_d = '0;
    end else begin
      starve_d = starve_q;
    end

    rf_waddr_d     = rf_waddr_q;
    rf_wdata_d     = rf_wdata_q;
    commit_pc_d    = commit_pc_q;
    rf_wen_d       = 1'b0;
    commit_valid_d = 1'b0;
    instret_d      = instret_q;
    if (any_sel) begin
      rf_waddr_d     = sel_res.rd;
      rf_wdata_d     = sel_res.wdata;
      commit_pc_d    = sel_res.pc;
      // x0 retires like any other instruction but never reaches the register file.
      rf_wen_d       = sel_res.wen && (sel_res.rd != '0);
      commit_valid_d = 1'b1;
      instret_d      = instret_q + 64'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      exu_v_q        <= 1'b0;
      lsu_v_q        <= 1'b0;
      exu_buf_q      <= '0;
      lsu_buf_q      <= '0;
      starve_q       <= '0;
      rf_waddr_q     <= '0;
      rf_wdata_q     <= '0;
      rf_wen_q       <= 1'b0;
      commit_valid_q <= 1'b0;
      commit_pc_q    <= '0;
      instret_q      <= '0;
    end else begin
      exu_v_q        <= exu_v_d;
      lsu_v_q        <= lsu_v_d;
      exu_buf_q      <= exu_buf_d;
      lsu_buf_q      <= lsu_buf_d;
      starve_q       <= starve_d;
      rf_waddr_q     <= rf_waddr_d;
      rf_wdata_q     <= rf_wdata_d;
      rf_wen_q       <= rf_wen_d;
      commit_valid_q <= commit_valid_d;
      commit_pc_q    <= commit_pc_d;
      instret_q      <= instret_d;
    end
  end

  assign rf_waddr     = rf_waddr_q;
  assign rf_wdata     = rf_wdata_q;
  assign rf_wen       = rf_wen_q;
  assign commit_valid = commit_valid_q;
  assign commit_pc    = commit_pc_q;
  assign instret      = instret_q;

endmodule

`default_nettype wire

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: table-driven checks of wb_arbiter plus a mid-operation reset sequence.
`default_nettype none

module tb_wb_arbiter;

  logic        clk;
  logic        rst;
  logic        exu_valid, exu_ready, exu_wen;
  logic [4:0]  exu_rd;
  logic [31:0] exu_wdata, exu_pc;
  logic        lsu_valid, lsu_ready, lsu_wen;
  logic [4:0]  lsu_rd;
  logic [31:0] lsu_wdata, lsu_pc;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        rf_wen;
  logic        commit_valid;
  logic [31:0] commit_pc;
  logic [63:0] instret;

  wb_arbiter #(.XLEN(32), .WIDTH(5), .STARVE_MAX(2)) dut (
    .clk(clk), .rst(rst),
    .exu_valid(exu_valid), .exu_ready(exu_ready), .exu_rd(exu_rd),
    .exu_wdata(exu_wdata), .exu_wen(exu_wen), .exu_pc(exu_pc),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd),
    .lsu_wdata(lsu_wdata), .lsu_wen(lsu_wen), .lsu_pc(lsu_pc),
    .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .rf_wen(rf_wen),
    .commit_valid(commit_valid), .commit_pc(commit_pc), .instret(instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        ev;
    logic [4:0]  erd;
    logic [31:0] ewd;
    logic        ewen;
    logic [31:0] epc;
    logic        lv;
    logic [4:0]  lrd;
    logic [31:0] lwd;
    logic [31:0] lpc;
    logic        x_er;
    logic        x_lr;
    logic        x_cv;
    logic        x_wen;
    logic [4:0]  x_wa;
    logic [31:0] x_wd;
    logic [31:0] x_pc;
    logic [63:0] x_ir;
  } vec_t;

  vec_t vecs[$];
  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic add(input logic ev, input logic [4:0] erd, input logic [31:0] ewd,
                     input logic ewen, input logic [31:0] epc,
                     input logic lv, input logic [4:0] lrd, input logic [31:0] lwd,
                     input logic [31:0] lpc,
                     input logic er, input logic lr, input logic cv, input logic wen,
                     input logic [4:0] wa, input logic [31:0] wd, input logic [31:0] pc,
                     input logic [63:0] ir);
    vec_t v;
    v.ev = ev; v.erd = erd; v.ewd = ewd; v.ewen = ewen; v.epc = epc;
    v.lv = lv; v.lrd = lrd; v.lwd = lwd; v.lpc = lpc;
    v.x_er = er; v.x_lr = lr; v.x_cv = cv; v.x_wen = wen;
    v.x_wa = wa; v.x_wd = wd; v.x_pc = pc; v.x_ir = ir;
    vecs.push_back(v);
  endtask

  task automatic drive_idle();
    exu_valid = 1'b0; exu_rd = '0; exu_wdata = '0; exu_wen = 1'b0; exu_pc = '0;
    lsu_valid = 1'b0; lsu_rd = '0; lsu_wdata = '0; lsu_wen = 1'b0; lsu_pc = '0;
  endtask

  task automatic chk_outputs(input string tag, input logic cv, input logic wen,
                             input logic [4:0] wa, input logic [31:0] wd,
                             input logic [31:0] pc, input logic [63:0] ir);
    chk({tag, ".commit_valid"}, {63'd0, commit_valid}, {63'd0, cv});
    chk({tag, ".rf_wen"}, {63'd0, rf_wen}, {63'd0, wen});
    chk({tag, ".rf_waddr"}, {59'd0, rf_waddr}, {59'd0, wa});
    chk({tag, ".rf_wdata"}, {32'd0, rf_wdata}, {32'd0, wd});
    chk({tag, ".commit_pc"}, {32'd0, commit_pc}, {32'd0, pc});
    chk({tag, ".instret"}, instret, ir);
  endtask

  initial begin
    // Single EXU op
    add(1, 5'd5, 32'hDEADBEEF, 1, 32'h80000000, 0, 0, 0, 0,  1, 1,  0, 0, 5'd0, 32'h0, 32'h0, 64'd0);
    add(0, 0, 0, 0, 0,                            0, 0, 0, 0,  1, 1,  1, 1, 5'd5, 32'hDEADBEEF, 32'h80000000, 64'd1);
    // Conflict: LSU first, EXU waits with ready low
    add(1, 5'd1, 32'h11, 1, 32'h100,    1, 5'd2, 32'h22, 32'h200,  1, 1,  0, 0, 5'd5, 32'hDEADBEEF, 32'h80000000, 64'd1);
    add(0, 0, 0, 0, 0,                  0, 0, 0, 0,                0, 1,  1, 1, 5'd2, 32'h22, 32'h200, 64'd2);
    add(0, 0, 0, 0, 0,                  0, 0, 0, 0,                1, 1,  1, 1, 5'd1, 32'h11, 32'h100, 64'd3);
    // Starvation: LSU streams, EXU forced through on the third drain
    add(1, 5'd3, 32'h33, 1, 32'h300,    1, 5'd4, 32'h40, 32'h400,  1, 1,  0, 0, 5'd1, 32'h11, 32'h100, 64'd3);
    add(0, 0, 0, 0, 0,                  1, 5'd5, 32'h41, 32'h404,  0, 1,  1, 1, 5'd4, 32'h40, 32'h400, 64'd4);
    add(0, 0, 0, 0, 0,                  1, 5'd6, 32'h42, 32'h408,  0, 1,  1, 1, 5'd5, 32'h41, 32'h404, 64'd5);
    add(0, 0, 0, 0, 0,                  1, 5'd7, 32'h43, 32'h40C,  1, 0,  1, 1, 5'd3, 32'h33, 32'h300, 64'd6);
    add(0, 0, 0, 0, 0,                  1, 5'd7, 32'h43, 32'h40C,  1, 1,  1, 1, 5'd6, 32'h42, 32'h408, 64'd7);
    add(0, 0, 0, 0, 0,                  0, 0, 0, 0,                1, 1,  1, 1, 5'd7, 32'h43, 32'h40C, 64'd8);
    // x0 write retires without a register-file write
    add(1, 5'd0, 32'h1234, 1, 32'h500,  0, 0, 0, 0,                1, 1,  0, 0, 5'd7, 32'h43, 32'h40C, 64'd8);
    add(0, 0, 0, 0, 0,                  0, 0, 0, 0,                1, 1,  1, 0, 5'd0, 32'h1234, 32'h500, 64'd9);
    // wen=0 instruction retires without a write
    add(1, 5'd9, 32'h77, 0, 32'h520,    0, 0, 0, 0,                1, 1,  0, 0, 5'd0, 32'h1234, 32'h500, 64'd9);
    add(0, 0, 0, 0, 0,                  0, 0, 0, 0,                1, 1,  1, 0, 5'd9, 32'h77, 32'h520, 64'd10);
    // Back-to-back EXU streaming, 8 results
    for (int i = 0; i < 8; i++) begin
      if (i == 0)
        add(1, 5'(8 + i), 32'h1000 + 32'(i), 1, 32'h600 + 32'(4 * i), 0, 0, 0, 0,
            1, 1, 0, 0, 5'd9, 32'h77, 32'h520, 64'd10);
      else
        add(1, 5'(8 + i), 32'h1000 + 32'(i), 1, 32'h600 + 32'(4 * i), 0, 0, 0, 0,
            1, 1, 1, 1, 5'(7 + i), 32'h1000 + 32'(i - 1), 32'h600 + 32'(4 * (i - 1)), 64'(10 + i));
    end
    add(0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 1,  1, 1, 5'd15, 32'h1007, 32'h61C, 64'd18);

    // Reset held for 3 cycles
    rst = 1'b0;
    drive_idle();
    repeat (3) @(posedge clk);
    #1;
    chk_outputs("reset", 0, 0, 5'd0, 32'h0, 32'h0, 64'd0);
    chk("reset.exu_ready", {63'd0, exu_ready}, 64'd1);
    chk("reset.lsu_ready", {63'd0, lsu_ready}, 64'd1);
    @(negedge clk);
    rst = 1'b1;

    foreach (vecs[k]) begin
      @(negedge clk);
      exu_valid = vecs[k].ev; exu_rd = vecs[k].erd; exu_wdata = vecs[k].ewd;
      exu_wen = vecs[k].ewen; exu_pc = vecs[k].epc;
      lsu_valid = vecs[k].lv; lsu_rd = vecs[k].lrd; lsu_wdata = vecs[k].lwd;
      lsu_wen = 1'b1; lsu_pc = vecs[k].lpc;
      #1;
      chk($sformatf("v%0d.exu_ready", k), {63'd0, exu_ready}, {63'd0, vecs[k].x_er});
      chk($sformatf("v%0d.lsu_ready", k), {63'd0, lsu_ready}, {63'd0, vecs[k].x_lr});
      @(posedge clk);
      #1;
      chk_outputs($sformatf("v%0d", k), vecs[k].x_cv, vecs[k].x_wen, vecs[k].x_wa,
                  vecs[k].x_wd, vecs[k].x_pc, vecs[k].x_ir);
    end

    // Mid-operation reset with both buffers full
    @(negedge clk);
    exu_valid = 1'b1; exu_rd = 5'd20; exu_wdata = 32'hAAAA; exu_wen = 1'b1; exu_pc = 32'h700;
    lsu_valid = 1'b1; lsu_rd = 5'd21; lsu_wdata = 32'hBBBB; lsu_wen = 1'b1; lsu_pc = 32'h704;
    @(posedge clk);
    #1;
    chk("midrst.pre_exu_ready", {63'd0, exu_ready}, 64'd0);
    @(negedge clk);
    drive_idle();
    rst = 1'b0;
    #1;
    chk_outputs("midrst.async", 0, 0, 5'd0, 32'h0, 32'h0, 64'd0);
    chk("midrst.exu_ready", {63'd0, exu_ready}, 64'd1);
    chk("midrst.lsu_ready", {63'd0, lsu_ready}, 64'd1);
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      chk_outputs($sformatf("postrst%0d", c), 0, 0, 5'd0, 32'h0, 32'h0, 64'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
